// File: rtl/sp_reorder_buf_pkg.sv
// Shared constants, types and size helpers for the FFT serial-to-parallel reorder buffer.
package fft_sp_pkg;

  localparam logic ORD_STRIDE = 1'b0;
  localparam logic ORD_CONTIG = 1'b1;

  typedef enum logic {IDLE, LOAD} rd_state_e;

  // Number of parallel output words per frame.
  function automatic int words_per_frame(input int n_pts, input int radix);
    return n_pts / radix;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sp_reorder_buf_if.sv
// Sample-in / word-out handshake bundle of the reorder buffer.
interface sp_reorder_buf_if #(
  parameter int DATA_W = 34,
  parameter int RADIX  = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic                    in_sop;
  logic                    order_mode;
  logic                    out_valid;
  logic                    out_ready;
  logic [RADIX*DATA_W-1:0] out_data;
  logic                    out_sop;
  logic                    out_eop;
  logic                    err_resync;

  modport master (
    output in_valid, in_data, in_sop, order_mode, out_ready,
    input  in_ready, out_valid, out_data, out_sop, out_eop, err_resync
  );

  modport slave (
    input  in_valid, in_data, in_sop, order_mode, out_ready,
    output in_ready, out_valid, out_data, out_sop, out_eop, err_resync
  );
endinterface

// File: rtl/sp_reorder_buf_bank.sv
// One N_PTS x DATA_W sample bank: single write port, RADIX independent read lanes.
module sp_bank
  import fft_sp_pkg::*;
#(
  parameter int DATA_W = 34,
  parameter int N_PTS  = 16,
  parameter int RADIX  = 4,
  localparam int AW    = idx_w(N_PTS)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [RADIX*AW-1:0]     raddr,
  output logic [RADIX*DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [N_PTS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  for (genvar j = 0; j < RADIX; j++) begin : g_lane
    assign rdata[j*DATA_W +: DATA_W] = mem[raddr[j*AW +: AW]];
  end

endmodule

// File: rtl/sp_reorder_buf.sv
// Ping-pong serial-to-parallel converter: fills one bank per frame while the other
// drains as N_PTS/RADIX words in stride or contiguous order.
module sp_reorder_buf
  import fft_sp_pkg::*;
#(
  parameter int DATA_W = 34,
  parameter int N_PTS  = 16,
  parameter int RADIX  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  sp_reorder_buf_if.slave  bus
);

  localparam int S  = words_per_frame(N_PTS, RADIX);
  localparam int AW = idx_w(N_PTS);
  localparam int WW = idx_w(S);
  localparam logic [AW-1:0] LAST_S = AW'(N_PTS - 1);
  localparam logic [WW-1:0] LAST_W = WW'(S - 1);

  logic [1:0]    full_q;
  logic [1:0]    mode_q;
  logic          wb_q, rb_q, open_q, err_q;
  logic [AW-1:0] widx_q;
  logic [WW-1:0] ridx_q;

  rd_state_e     state_q, state_d;
  logic          load_en, load_bank, rel;
  logic [WW-1:0] load_word;

  logic                    vld_p1, sop_p1, eop_p1;
  logic [RADIX*DATA_W-1:0] data_p1;

  logic                    accept, wr_en, fill;
  logic [AW-1:0]           wr_addr;
  logic [1:0]              fill_set, rel_clr;
  logic [RADIX*AW-1:0]     raddr;
  logic [RADIX*DATA_W-1:0] rdata0, rdata1, rd_word;

  assign bus.in_ready   = ~full_q[wb_q];
  assign bus.out_valid  = vld_p1;
  assign bus.out_data   = data_p1;
  assign bus.out_sop    = sop_p1;
  assign bus.out_eop    = eop_p1;
  assign bus.err_resync = err_q;

  assign accept  = bus.in_valid & ~full_q[wb_q];
  // Samples outside an open frame are dropped unless they start one.
  assign wr_en   = accept & (bus.in_sop | open_q);
  assign wr_addr = bus.in_sop ? '0 : widx_q;
  assign fill    = accept & ~bus.in_sop & open_q & (widx_q == LAST_S);
  assign fill_set = fill ? (2'b01 << wb_q) : 2'b00;
  assign rel_clr  = rel  ? (2'b01 << rb_q) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= '0;
      mode_q <= '0;
      wb_q   <= 1'b0;
      open_q <= 1'b0;
      widx_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (accept && bus.in_sop) begin
        open_q       <= 1'b1;
        widx_q       <= AW'(1);
        mode_q[wb_q] <= bus.order_mode;
        err_q        <= (widx_q != '0);
      end else if (accept && open_q) begin
        if (fill) begin
          widx_q <= '0;
          open_q <= 1'b0;
          wb_q   <= ~wb_q;
        end else begin
          widx_q <= widx_q + 1'b1;
        end
      end
      full_q <= (full_q | fill_set) & ~rel_clr;
    end
  end

  sp_bank #(.DATA_W(DATA_W), .N_PTS(N_PTS), .RADIX(RADIX)) u_bank0 (
    .clk(clk), .we(wr_en & ~wb_q), .waddr(wr_addr), .wdata(bus.in_data),
    .raddr(raddr), .rdata(rdata0)
  );

  sp_bank #(.DATA_W(DATA_W), .N_PTS(N_PTS), .RADIX(RADIX)) u_bank1 (
    .clk(clk), .we(wr_en & wb_q), .waddr(wr_addr), .wdata(bus.in_data),
    .raddr(raddr), .rdata(rdata1)
  );

  always_comb begin
    raddr = '0;
    for (int j = 0; j < RADIX; j++) begin
      if (mode_q[load_bank] == ORD_CONTIG)
        raddr[j*AW +: AW] = AW'(int'(load_word) * RADIX + j);
      else
        raddr[j*AW +: AW] = AW'(int'(load_word) + j * S);
    end
  end

  assign rd_word = load_bank ? rdata1 : rdata0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_en   = 1'b0;
    load_bank = rb_q;
    load_word = '0;
    rel       = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rb_q]) begin
          load_en = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (bus.out_ready) begin
          if (ridx_q == LAST_W) begin
            rel = 1'b1;
            // Chain straight into the other bank so back-to-back frames have no bubble.
            if (full_q[~rb_q]) begin
              load_en   = 1'b1;
              load_bank = ~rb_q;
            end else begin
              state_d = IDLE;
            end
          end else begin
            load_en   = 1'b1;
            load_word = ridx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output word register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_q    <= 1'b0;
      ridx_q  <= '0;
      vld_p1  <= 1'b0;
      sop_p1  <= 1'b0;
      eop_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      if (rel) rb_q <= ~rb_q;
      if (load_en) begin
        data_p1 <= rd_word;
        vld_p1  <= 1'b1;
        sop_p1  <= (load_word == '0);
        eop_p1  <= (load_word == LAST_W);
        ridx_q  <= load_word;
      end else if (rel) begin
        vld_p1 <= 1'b0;
        sop_p1 <= 1'b0;
        eop_p1 <= 1'b0;
        ridx_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sp_reorder_buf.sv
// Self-checking bench for sp_reorder_buf (16 points, radix 4, 34-bit samples).
module tb_sp_reorder_buf;

  localparam int W  = 34;
  localparam int N  = 16;
  localparam int R  = 4;
  localparam int S  = N / R;
  localparam int WB = R * W + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sp_reorder_buf_if #(.DATA_W(W), .RADIX(R)) bus ();

  sp_reorder_buf #(.DATA_W(W), .N_PTS(N), .RADIX(R)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int stall_err = 0;
  int err_cnt = 0;
  logic [WB-1:0] got[$];
  logic [WB-1:0] exp_q[$];

  bit           stall_pend = 1'b0;
  logic [R*W-1:0] prev_data;
  logic         prev_sop, prev_eop;

  // Output monitor: records accepted words, resync pulses and stall-hold violations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_pend && (!bus.out_valid || bus.out_data !== prev_data ||
                         bus.out_sop !== prev_sop || bus.out_eop !== prev_eop))
        stall_err++;
      if (bus.out_valid && bus.out_ready)
        got.push_back({bus.out_sop, bus.out_eop, bus.out_data});
      if (bus.err_resync) err_cnt++;
      stall_pend = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_sop   = bus.out_sop;
      prev_eop   = bus.out_eop;
    end else begin
      stall_pend = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Reference: word k lane j is x[k + j*S] (stride) or x[k*R + j] (contiguous).
  function automatic void add_frame(input logic [W-1:0] s[N], input bit mode);
    logic [R*W-1:0] w;
    logic sp, ep;
    int idx;
    for (int k = 0; k < S; k++) begin
      w = '0;
      for (int j = 0; j < R; j++) begin
        idx = mode ? (k * R + j) : (k + j * S);
        w[j*W +: W] = s[idx];
      end
      sp = (k == 0);
      ep = (k == S - 1);
      exp_q.push_back({sp, ep, w});
    end
  endfunction

  task automatic push(input logic [W-1:0] d, input bit sop, input bit mode);
    int g;
    g = 0;
    bus.in_valid   = 1'b1;
    bus.in_data    = d;
    bus.in_sop     = sop;
    bus.order_mode = sop ? mode : 1'($urandom_range(0, 1));
    @(negedge clk);
    while (!bus.in_ready && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) begin
      n_chk++;
      n_fail++;
      $display("FAIL push_timeout: in_ready=%0b, required 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int base, input bit mode, input bit rnd);
    logic [W-1:0] s[N];
    for (int i = 0; i < N; i++)
      s[i] = rnd ? W'({$urandom(), $urandom()}) : W'(base + i);
    add_frame(s, mode);
    for (int i = 0; i < N; i++) push(s[i], i == 0, mode);
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int g;
    g = 0;
    while (got.size() < n && g < 25000) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
    n_chk++; if (bus.out_sop !== 1'b0) begin n_fail++; $display("FAIL rst_out_sop got %b exp 0", bus.out_sop); end
    n_chk++; if (bus.out_eop !== 1'b0) begin n_fail++; $display("FAIL rst_out_eop got %b exp 0", bus.out_eop); end
    n_chk++; if (bus.err_resync !== 1'b0) begin n_fail++; $display("FAIL rst_err_resync got %b exp 0", bus.err_resync); end
    n_chk++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL rst_out_data got %h exp 0", bus.out_data); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stride();
    logic [R*W-1:0] w0, ref0;
    got.delete(); exp_q.delete();
    bus.out_ready = 1'b1;
    push_frame(0, 1'b0, 1'b0);
    idle_in();
    @(negedge clk);
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stride_lat_early out_valid got %b exp 0", bus.out_valid); end
    @(negedge clk);
    n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stride_lat_rise out_valid got %b exp 1", bus.out_valid); end
    wait_words(4);
    n_chk++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL stride_count got %0d exp %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL stride_word%0d got %h exp %h", i, got[i], exp_q[i]); end
    end
    ref0 = {34'd12, 34'd8, 34'd4, 34'd0};
    w0 = (got.size() > 0) ? got[0][R*W-1:0] : '0;
    n_chk++; if (w0 !== ref0) begin n_fail++; $display("FAIL stride_word0_literal got %h exp %h", w0, ref0); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_contig();
    logic [R*W-1:0] w3, ref3;
    got.delete(); exp_q.delete();
    bus.out_ready = 1'b1;
    push_frame(0, 1'b1, 1'b0);
    idle_in();
    wait_words(4);
    n_chk++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL contig_count got %0d exp %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL contig_word%0d got %h exp %h", i, got[i], exp_q[i]); end
    end
    ref3 = {34'd15, 34'd14, 34'd13, 34'd12};
    w3 = (got.size() > 3) ? got[3][R*W-1:0] : '0;
    n_chk++; if (w3 !== ref3) begin n_fail++; $display("FAIL contig_word3_literal got %h exp %h", w3, ref3); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    got.delete(); exp_q.delete();
    stall_err = 0;
    bus.out_ready = 1'b0;
    push_frame(0, 1'b0, 1'b0);
    push_frame(16, 1'b0, 1'b0);
    idle_in();
    n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_drop got %b exp 0", bus.in_ready); end
    repeat (5) @(negedge clk);
    n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_held got %b exp 0", bus.in_ready); end
    n_chk++; if ({bus.out_valid, bus.out_sop} !== 2'b11) begin n_fail++; $display("FAIL b2b_word0_held got %b exp 11", {bus.out_valid, bus.out_sop}); end
    fork
      push_frame(32, 1'b0, 1'b0);
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    idle_in();
    wait_words(12);
    n_chk++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count got %0d exp %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_word%0d got %h exp %h", i, got[i], exp_q[i]); end
    end
    n_chk++; if (stall_err != 0) begin n_fail++; $display("FAIL b2b_stall_hold got %0d changes exp 0", stall_err); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_resync();
    got.delete(); exp_q.delete();
    err_cnt = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(W'(50 + i), i == 0, 1'b0);
    push_frame(200, 1'b0, 1'b0);
    idle_in();
    wait_words(4);
    repeat (4) @(negedge clk);
    n_chk++; if (err_cnt != 1) begin n_fail++; $display("FAIL resync_pulses got %0d exp 1", err_cnt); end
    n_chk++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL resync_count got %0d exp %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL resync_word%0d got %h exp %h", i, got[i], exp_q[i]); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    got.delete(); exp_q.delete();
    stall_err = 0;
    fork
      begin
        for (int f = 0; f < 100; f++) push_frame(0, 1'($urandom_range(0, 1)), 1'b1);
        idle_in();
      end
      begin
        int g;
        g = 0;
        while (got.size() < 100 * S && g < 20000) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 99) >= 30);
          g++;
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_words(100 * S);
    n_chk++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d exp %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_word%0d got %h exp %h", i, got[i], exp_q[i]); end
    end
    n_chk++; if (stall_err != 0) begin n_fail++; $display("FAIL rand_stall_hold got %0d changes exp 0", stall_err); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_drain();
    logic [R*W-1:0] w0, ref0;
    got.delete(); exp_q.delete();
    bus.out_ready = 1'b0;
    push_frame(0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) push(W'(50 + i), i == 0, 1'b0);
    idle_in();
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid got %b exp 0", bus.out_valid); end
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_in_ready got %b exp 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    got.delete(); exp_q.delete();
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    push_frame(100, 1'b0, 1'b0);
    idle_in();
    wait_words(4);
    repeat (4) @(negedge clk);
    n_chk++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_rst_count got %0d exp %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_rst_word%0d got %h exp %h", i, got[i], exp_q[i]); end
    end
    ref0 = {34'd112, 34'd108, 34'd104, 34'd100};
    w0 = (got.size() > 0) ? got[0][R*W-1:0] : '0;
    n_chk++; if (w0 !== ref0) begin n_fail++; $display("FAIL mid_rst_word0_literal got %h exp %h", w0, ref0); end
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_sop     = 1'b0;
    bus.order_mode = 1'b0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_stride();
    test_contig();
    test_back_to_back();
    test_resync();
    test_random();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
